// File: rtl/mem_port_arbiter_pkg.sv
// arb_structs: shared types for the memory port arbiter.
// Holds the arbiter states, the latched command bundle and defaults.
package arb_structs;

    localparam int unsigned DEF_STARVE_LIMIT = 4;
    localparam int unsigned STREAK_W         = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic        read;
        logic        write;
        logic [31:0] address;
        logic [31:0] wdata;
        logic [3:0]  byte_enable;
    } mem_cmd_t;

endpackage

// File: rtl/arb_starve_counter.sv
// arb_starve_counter: counts consecutive D grants taken while fetch waits.
// Saturates at STARVE_LIMIT; at_limit tells the arbiter to let fetch win.
module arb_starve_counter
    import arb_structs::*;
#(
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clear,
    output logic at_limit
);

    localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(STARVE_LIMIT);

    logic [STREAK_W-1:0] streak;

    // saturating streak register; clear wins over increment
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            streak <= '0;
        end else if (inc && (streak != LIMIT)) begin
            streak <= streak + STREAK_W'(1);
        end
    end

    assign at_limit = (streak == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch (I) and LSU (D).
// D has priority; a bounded D streak forces fetch to make progress.
module mem_port_arbiter
    import arb_structs::*;
#(
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_mem_read,
    input  logic [31:0]      i_mem_address,
    output logic [31:0]      i_mem_rdata,
    output logic             i_mem_resp,
    input  logic             d_mem_read,
    input  logic             d_mem_write,
    input  logic [31:0]      d_mem_address,
    input  logic [31:0]      d_mem_wdata,
    input  logic [3:0]       d_mem_byte_enable,
    output logic [31:0]      d_mem_rdata,
    output logic             d_mem_resp,
    output logic             mem_read,
    output logic             mem_write,
    output logic [31:0]      mem_address,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_byte_enable,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_resp,
    output logic [CNT_W-1:0] i_wait_cycles
);

    arb_state_t       state;
    arb_state_t       state_next;
    mem_cmd_t         cmd;
    mem_cmd_t         cmd_next;
    logic             i_req;
    logic             d_req;
    logic             d_win;
    logic             i_win;
    logic             streak_inc;
    logic             streak_clr;
    logic             at_limit;
    logic [CNT_W-1:0] wait_cnt;

    assign i_req = i_mem_read;
    assign d_req = d_mem_read | d_mem_write;

    // D wins unless fetch has already waited out its allowance
    assign d_win = (state == IDLE) && d_req && !(i_req && at_limit);
    assign i_win = (state == IDLE) && !d_win && i_req;

    // streak only grows while fetch is actually being passed over
    assign streak_inc = d_win && i_req;
    assign streak_clr = i_win || (d_win && !i_req);

    arb_starve_counter #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk     (clk),
        .rst     (rst),
        .inc     (streak_inc),
        .clear   (streak_clr),
        .at_limit(at_limit)
    );

    // state and latched command; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cmd   <= '0;
        end else begin
            state <= state_next;
            cmd   <= cmd_next;
        end
    end

    // arbitration, command capture, port drive and response routing
    always_comb begin
        state_next      = state;
        cmd_next        = cmd;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_address     = '0;
        mem_wdata       = '0;
        mem_byte_enable = '0;
        i_mem_resp      = 1'b0;
        i_mem_rdata     = '0;
        d_mem_resp      = 1'b0;
        d_mem_rdata     = '0;

        if (state != IDLE) begin
            mem_read        = cmd.read & ~mem_resp;
            mem_write       = cmd.write & ~mem_resp;
            mem_address     = cmd.address;
            mem_wdata       = cmd.wdata;
            mem_byte_enable = cmd.byte_enable;
        end

        unique case (state)
            IDLE: begin
                if (d_win) begin
                    state_next           = GRANT_D;
                    cmd_next.write       = d_mem_write;
                    cmd_next.read        = ~d_mem_write;
                    cmd_next.address     = d_mem_address;
                    cmd_next.wdata       = d_mem_wdata;
                    cmd_next.byte_enable = d_mem_byte_enable;
                end else if (i_win) begin
                    state_next           = GRANT_I;
                    cmd_next.write       = 1'b0;
                    cmd_next.read        = 1'b1;
                    cmd_next.address     = i_mem_address;
                    cmd_next.wdata       = '0;
                    cmd_next.byte_enable = '0;
                end
            end
            GRANT_I: begin
                i_mem_resp  = mem_resp;
                i_mem_rdata = mem_resp ? mem_rdata : '0;
                if (mem_resp) begin
                    state_next = IDLE;
                end
            end
            GRANT_D: begin
                d_mem_resp  = mem_resp;
                d_mem_rdata = mem_resp ? mem_rdata : '0;
                if (mem_resp) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // fetch wait counter: pending but not owning the port, wraps
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (i_req && (state != GRANT_I)) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    assign i_wait_cycles = wait_cnt;

    // a simultaneous load and store is undefined upstream; it is served as a store
    dual_d_request: assert property (
        @(posedge clk) disable iff (rst) !(d_mem_read && d_mem_write)
    ) else $warning("mem_port_arbiter: d_mem_read and d_mem_write both high, served as store");

endmodule
